// File: rtl/sram_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the SRAM controller.
// Optional power-on clear sweep is enabled by defining SRAM_CTRL_CLEAR_EN.
package sram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 11;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned MEM_DEPTH  = 2048;

  typedef enum logic [2:0] {
`ifdef SRAM_CTRL_CLEAR_EN
    ST_CLEAR,
`endif
    ST_IDLE,
    ST_WRITE,
    ST_READ1,
    ST_READ2
  } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: one-cycle writes, two-cycle reads.
// Define SRAM_CTRL_CLEAR_EN to zero the whole array after every reset.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqWrData,
  output logic              respValid,
  output logic [DATA_W-1:0] respData,
  output logic              clearDone,
  output logic              chipSelect,
  output logic              outEnable,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] address,
  inout  logic [DATA_W-1:0] data
);

`ifdef SRAM_CTRL_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t            state_q;
  state_t            state_d;
  logic              handshake;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] bus_wdata;
  logic              drive_en;

`ifdef SRAM_CTRL_CLEAR_EN
  logic [ADDR_W-1:0] sweep;
  // Holds the sweep off while reset is still asserted so strobes stay low.
  logic              in_reset;
`endif

  assign handshake = (state_q == ST_IDLE) && reqValid;

  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    reqReady    = 1'b0;
    chipSelect  = 1'b0;
    outEnable   = 1'b0;
    writeEnable = 1'b0;
    drive_en    = 1'b0;
    bus_wdata   = lat_wdata;
    address     = lat_addr;
    unique case (state_q)
      ST_IDLE: begin
        reqReady = 1'b1;
        if (reqValid) state_d = reqWrite ? ST_WRITE : ST_READ1;
      end
      ST_WRITE: begin
        chipSelect  = 1'b1;
        writeEnable = 1'b1;
        drive_en    = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_READ1: begin
        chipSelect = 1'b1;
        outEnable  = 1'b1;
        state_d    = ST_READ2;
      end
      ST_READ2: begin
        chipSelect = 1'b1;
        outEnable  = 1'b1;
        state_d    = ST_IDLE;
      end
`ifdef SRAM_CTRL_CLEAR_EN
      ST_CLEAR: begin
        address   = sweep;
        bus_wdata = '0;
        if (!in_reset) begin
          chipSelect  = 1'b1;
          writeEnable = 1'b1;
          drive_en    = 1'b1;
          if (&sweep) state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      respValid <= 1'b0;
      respData  <= '0;
      clearDone <= 1'b0;
`ifdef SRAM_CTRL_CLEAR_EN
      sweep     <= '0;
      in_reset  <= 1'b1;
`endif
    end else begin
      respValid <= 1'b0;
      if (handshake) begin
        lat_addr  <= reqAddr;
        lat_wdata <= reqWrData;
      end
      if (state_q == ST_READ2) begin
        respData  <= data;
        respValid <= 1'b1;
      end
`ifdef SRAM_CTRL_CLEAR_EN
      in_reset <= 1'b0;
      // Stop on the last address instead of wrapping back to zero.
      if (state_q == ST_CLEAR && !in_reset) begin
        if (&sweep) clearDone <= 1'b1;
        else        sweep     <= sweep + ADDR_W'(1);
      end
`else
      clearDone <= 1'b1;
`endif
    end
  end

  assign data = drive_en ? bus_wdata : 'z;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed self-checking bench for sram_ctrl with a behavioural async SRAM.
// Also builds with SRAM_CTRL_CLEAR_EN defined to exercise the clear sweep.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          reqValid;
  logic          reqReady;
  logic          reqWrite;
  logic [AW-1:0] reqAddr;
  logic [DW-1:0] reqWrData;
  logic          respValid;
  logic [DW-1:0] respData;
  logic          clearDone;
  logic          chipSelect;
  logic          outEnable;
  logic          writeEnable;
  logic [AW-1:0] address;
  wire  [DW-1:0] data;

  logic [DW-1:0] sRam [0:MEM_DEPTH-1];
  int unsigned   wr_aa = 0;

  int checks   = 0;
  int failures = 0;
  int busy;
  int unsigned wr_aa_before;

  always #5 clk = ~clk;

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .reqWrite   (reqWrite),
    .reqAddr    (reqAddr),
    .reqWrData  (reqWrData),
    .respValid  (respValid),
    .respData   (respData),
    .clearDone  (clearDone),
    .chipSelect (chipSelect),
    .outEnable  (outEnable),
    .writeEnable(writeEnable),
    .address    (address),
    .data       (data)
  );

  assign data = (chipSelect && outEnable && !writeEnable) ? sRam[address] : 'z;

  always @(posedge clk) begin
    if (chipSelect && writeEnable) begin
      sRam[address] <= data;
      if (address == 11'h0AA) wr_aa <= wr_aa + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    chk("no_contention", 32'(dut.drive_en && outEnable), 32'd0);
    if (!chipSelect) chk("bus_released_when_deselected", 32'(dut.drive_en), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b0;
`ifdef SRAM_CTRL_CLEAR_EN
    @(posedge clk); #1;
    busy = 0;
    while (busy < 4000) begin
      at_neg();
      if (reqReady) break;
      busy++;
    end
    reqValid = 1'b0;
    reqWrite = 1'b0;
    chk("clear_busy_cycles", 32'(busy), 32'd2048);
    chk("clear_done_set", 32'(clearDone), 32'd1);
`else
    @(posedge clk); #1;
    chk("clear_done_immediate", 32'(clearDone), 32'd1);
`endif
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = a; reqWrData = d;
    at_neg();
    chk("wr_ready", 32'(reqReady), 32'd1);
    @(posedge clk); #1;
    reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWrData = '0;
    at_neg();
    chk("wr_strobes", 32'({chipSelect, writeEnable, outEnable}), 32'(3'b110));
    chk("wr_addr", 32'(address), 32'(a));
    @(posedge clk); #1;
    chk("wr_mem", 32'(sRam[a]), 32'(d));
    chk("wr_back_idle", 32'(reqReady), 32'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input bit junk);
    @(posedge clk); #1;
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = a;
    at_neg();
    chk("rd_ready", 32'(reqReady), 32'd1);
    @(posedge clk); #1;
    if (junk) begin
      reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 11'h0AA; reqWrData = 8'hEE;
    end else begin
      reqValid = 1'b0; reqAddr = '0;
    end
    at_neg();
    chk("rd1_strobes", 32'({chipSelect, writeEnable, outEnable}), 32'(3'b101));
    chk("rd1_addr", 32'(address), 32'(a));
    chk("rd1_no_resp", 32'(respValid), 32'd0);
    chk("rd1_not_ready", 32'(reqReady), 32'd0);
    @(posedge clk); #1;
    at_neg();
    chk("rd2_strobes", 32'({chipSelect, writeEnable, outEnable}), 32'(3'b101));
    chk("rd2_no_resp", 32'(respValid), 32'd0);
    chk("rd2_not_ready", 32'(reqReady), 32'd0);
    @(posedge clk); #1;
    reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0;
    at_neg();
    chk("rd_resp_valid", 32'(respValid), 32'd1);
    chk("rd_resp_data", 32'(respData), 32'(exp));
    chk("rd_idle_strobes", 32'({chipSelect, writeEnable, outEnable}), 32'd0);
    @(posedge clk); #1;
    chk("rd_resp_one_pulse", 32'(respValid), 32'd0);
    chk("rd_resp_held", 32'(respData), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWrData = '0;
    repeat (2) @(posedge clk);
    at_neg();
    chk("rst_strobes", 32'({chipSelect, writeEnable, outEnable}), 32'd0);
    chk("rst_resp_valid", 32'(respValid), 32'd0);
    chk("rst_resp_data", 32'(respData), 32'd0);
    chk("rst_clear_done", 32'(clearDone), 32'd0);
    chk("rst_bus_released", 32'(dut.drive_en), 32'd0);
    release_reset();

    do_write(11'h005, 8'hA5);
    do_read(11'h005, 8'hA5, 1'b0);

    do_write(11'h7FF, 8'h5A);
    do_write(11'h000, 8'hC3);
    do_write(11'h0AA, 8'h11);

    // back-to-back reads with reqValid held high
    @(posedge clk); #1;
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 11'h7FF;
    @(posedge clk); #1;
    reqAddr = 11'h000;
    at_neg();
    chk("b2b_rd1_addr", 32'(address), 32'h7FF);
    @(posedge clk);
    @(posedge clk); #1;
    at_neg();
    chk("b2b_resp1_valid", 32'(respValid), 32'd1);
    chk("b2b_resp1_data", 32'(respData), 32'h5A);
    chk("b2b_ready_with_resp", 32'(reqReady), 32'd1);
    @(posedge clk); #1;
    reqValid = 1'b0; reqAddr = '0;
    at_neg();
    chk("b2b_second_accepted", 32'({chipSelect, writeEnable, outEnable}), 32'(3'b101));
    chk("b2b_rd2_addr", 32'(address), 32'h000);
    chk("b2b_resp1_held", 32'(respData), 32'h5A);
    @(posedge clk);
    @(posedge clk); #1;
    at_neg();
    chk("b2b_resp2_valid", 32'(respValid), 32'd1);
    chk("b2b_resp2_data", 32'(respData), 32'hC3);

    // write request presented while a read is in flight is ignored
    wr_aa_before = wr_aa;
    do_read(11'h005, 8'hA5, 1'b1);
    chk("busy_req_no_write", 32'(wr_aa), 32'(wr_aa_before));
    chk("busy_req_mem_kept", 32'(sRam[11'h0AA]), 32'h11);

    do_write(11'h100, 8'h3C);

    // reset while in READ1
    @(posedge clk); #1;
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 11'h005;
    @(posedge clk); #1;
    reqValid = 1'b0; reqAddr = '0;
    at_neg();
    chk("abort_in_read1", 32'(outEnable), 32'd1);
    reset = 1'b1;
`ifdef SRAM_CTRL_CLEAR_EN
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 11'h0AA; reqWrData = 8'hEE;
`endif
    @(posedge clk); #1;
    chk("abort_no_resp", 32'(respValid), 32'd0);
    chk("abort_strobes", 32'({chipSelect, writeEnable, outEnable}), 32'd0);
    chk("abort_resp_data", 32'(respData), 32'd0);
    @(posedge clk); #1;
    chk("abort_still_no_resp", 32'(respValid), 32'd0);
    release_reset();
    chk("post_reset_no_resp", 32'(respValid), 32'd0);

`ifdef SRAM_CTRL_CLEAR_EN
    do_read(11'h100, 8'h00, 1'b0);
    chk("clear_ignored_req_0aa", 32'(sRam[11'h0AA]), 32'h00);
`else
    do_read(11'h100, 8'h3C, 1'b0);
    chk("mem_kept_0aa", 32'(sRam[11'h0AA]), 32'h11);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
